// File: rtl/bram_row_packer.sv
// Packs a 32-bit valid/ready word stream into 192-bit BRAM rows, one write strobe per row.
// Optional BRAM_PACK_WRAP_EN: address counter wraps at DEPTH-1 instead of halting with full.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting words into the row register
// FLUSH | final row write in flight, done follows
// HALT  | address space exhausted, waiting for a new start
module bram_row_packer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 192,
  parameter int DEPTH      = 2048,
  parameter int IN_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  full
);

  localparam int LANES  = DATA_WIDTH / IN_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
`ifdef BRAM_PACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, HALT} state_t;

  state_t                  state, state_nxt;
  logic [LANE_W-1:0]       lane_cnt;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [DATA_WIDTH-1:0]   row_reg, row_merged;
  logic                    accept, row_done, at_top, launch;

  assign in_ready = (state == FILL) && !full;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign row_done = accept && ((lane_cnt == LAST_LANE) || in_last);
  assign at_top   = (addr_cnt == LAST_ADDR);
  assign launch   = start && ((state == IDLE) || (state == HALT));

  // Row as it will look once the current word lands; written straight to BRAM on completion.
  always_comb begin
    row_merged = row_reg;
    for (int k = 0; k < LANES; k++) begin
      if (lane_cnt == LANE_W'(k)) row_merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FILL;
      FILL: begin
        if (row_done) begin
          if (in_last)                 state_nxt = FLUSH;
          else if (at_top && !WRAP_EN) state_nxt = HALT;
        end
      end
      FLUSH: state_nxt = IDLE;
      HALT:  if (start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lane_cnt <= '0;
      addr_cnt <= '0;
      row_reg  <= '0;
      we       <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= row_done;
      done  <= (state == FLUSH);
      if (row_done) begin
        wr_addr <= addr_cnt;
        wr_data <= row_merged;
      end
      if (launch) begin
        addr_cnt <= base_addr;
        lane_cnt <= '0;
        row_reg  <= '0;
      end else if (row_done) begin
        addr_cnt <= at_top ? '0 : addr_cnt + 1'b1;
        lane_cnt <= '0;
        row_reg  <= '0;
      end else if (accept) begin
        lane_cnt <= lane_cnt + 1'b1;
        row_reg  <= row_merged;
      end
    end
  end

`ifdef BRAM_PACK_WRAP_EN
  assign full = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          full <= 1'b0;
    else if (launch)                     full <= 1'b0;
    else if (row_done && !in_last && at_top) full <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bram_row_packer.sv
// Self-checking bench for bram_row_packer: table of bursts plus reset and exhaustion sequences.
module tb_bram_row_packer;

  localparam int AW = 11;
  localparam int DW = 192;
  localparam int IW = 32;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, full;

  bram_row_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    int            nwords;
    bit            last;
    logic [IW-1:0] w0;
    logic [IW-1:0] step;
    bit            gap;
    bit            nobubble;
    int            exp_we;
    bit            exp_full;
  } rec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            we_cnt = 0;
  int            last_we_cyc = 0;
  int            prev_we_cyc = 0;
  logic [DW-1:0] last_data = '0;

  logic [AW-1:0] m_addr;
  int            m_lane;
  logic [DW-1:0] m_row;
  bit            m_halt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected row.
  always @(negedge clk) begin
    if (rst_n && we) begin
      we_cnt++;
      prev_we_cyc = last_we_cyc;
      last_we_cyc = cyc;
      last_data   = wr_data;
      if (sb.size() == 0) begin
        chk("unexpected_we", {181'd0, wr_addr}, {DW{1'b0}});
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {181'd0, wr_addr}, {181'd0, e.addr});
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic model_accept(input logic [IW-1:0] w, input bit last);
    wr_t e;
    m_row[m_lane*IW +: IW] = w;
    if (m_lane == DW/IW - 1 || last) begin
      e.addr = m_addr;
      e.data = m_row;
      sb.push_back(e);
`ifndef BRAM_PACK_WRAP_EN
      if (m_addr == AW'(DEPTH - 1) && !last) m_halt = 1'b1;
`endif
      m_addr = (m_addr == AW'(DEPTH - 1)) ? '0 : m_addr + 1'b1;
      m_lane = 0;
      m_row  = '0;
    end else begin
      m_lane++;
    end
  endtask

  task automatic run_burst(input rec_t r, output int n_we);
    int i = 0;
    int guard = 0;
    int snap;
    bit gap_done = 1'b0;
    logic [IW-1:0] w;
    snap = we_cnt;
    @(negedge clk);
    start = 1'b1;
    base_addr = r.base;
    m_addr = r.base; m_lane = 0; m_row = '0; m_halt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (i < r.nwords && !m_halt && guard < 200) begin
      if (r.gap && i == 2 && !gap_done) begin
        gap_done = 1'b1;
        in_valid = 1'b0;
      end else begin
        w = r.w0 + IW'(i) * r.step;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = r.last && (i == r.nwords - 1);
        if (in_ready) begin
          model_accept(w, in_last);
          i++;
        end else if (r.nobubble) begin
          chk("no_bubble_ready", {191'd0, in_ready}, {{191{1'b0}}, 1'b1});
        end
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (guard >= 200) chk("burst_timeout", guard, 0);
    if (r.last) begin
      chk("we_latency", {191'd0, we}, {{191{1'b0}}, 1'b1});
      chk("done_early", {191'd0, done}, {DW{1'b0}});
      @(negedge clk);
      chk("done_pulse", {190'd0, done, busy}, {{190{1'b0}}, 2'b10});
      @(negedge clk);
      chk("done_single", {191'd0, done}, {DW{1'b0}});
    end else begin
      repeat (2) @(negedge clk);
    end
    n_we = we_cnt - snap;
  endtask

  rec_t tbl[6];
  int   n_we;

  initial begin
    tbl[0] = '{11'h010, 6,  1'b1, 32'h11111111, 32'h11111111, 1'b0, 1'b1, 1, 1'b0};
    tbl[1] = '{11'h000, 12, 1'b1, 32'h0000A000, 32'h00000001, 1'b0, 1'b1, 2, 1'b0};
    tbl[2] = '{11'h005, 3,  1'b1, 32'h0000000A, 32'h00000001, 1'b0, 1'b0, 1, 1'b0};
    tbl[3] = '{11'h100, 6,  1'b1, 32'hCAFE0000, 32'h00000010, 1'b1, 1'b0, 1, 1'b0};
    tbl[4] = '{11'h7FE, 12, 1'b1, 32'hB0000000, 32'h00000003, 1'b0, 1'b0, 2, 1'b0};
`ifdef BRAM_PACK_WRAP_EN
    tbl[5] = '{11'h7FF, 12, 1'b1, 32'hE0000000, 32'h00000001, 1'b0, 1'b0, 2, 1'b0};
`else
    tbl[5] = '{11'h7FF, 12, 1'b0, 32'hE0000000, 32'h00000001, 1'b0, 1'b0, 1, 1'b1};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {we, wr_addr, busy, done, full, in_ready}, '0);
    chk("reset_wr_data", wr_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_burst(tbl[t], n_we);
      chk($sformatf("we_count_%0d", t), n_we, tbl[t].exp_we);
      chk($sformatf("full_%0d", t), {191'd0, full}, {191'd0, tbl[t].exp_full});
      if (t == 0)
        chk("full_row_data", last_data,
            192'h666666665555555544444444333333332222222211111111);
      if (t == 1)
        chk("row_spacing", last_we_cyc - prev_we_cyc, 6);
      if (t == 2)
        chk("partial_row_data", last_data, {96'd0, 32'hC, 32'hB, 32'hA});
    end

`ifndef BRAM_PACK_WRAP_EN
    // Halted: nothing accepted, then a new start clears full.
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("halt_state", {188'd0, full, in_ready, busy, we}, {188'd0, 4'b1010});
    in_valid = 1'b0;
    start = 1'b1;
    base_addr = '0;
    @(negedge clk);
    start = 1'b0;
    chk("restart_clears_full", {190'd0, full, in_ready}, {190'd0, 2'b01});
    m_addr = '0; m_lane = 0; m_row = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h50000000 + IW'(i);
      in_last  = (i == 5);
      model_accept(in_data, in_last);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart_row_written", last_data,
        {32'h50000005, 32'h50000004, 32'h50000003, 32'h50000002, 32'h50000001, 32'h50000000});
`endif

    // Reset after 4 of 6 words: partial row must vanish.
    @(negedge clk);
    start = 1'b1;
    base_addr = 11'h020;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h77000000 + IW'(i);
      @(negedge clk);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midreset_outputs", {we, wr_addr, busy, done, full, in_ready}, '0);
    chk("midreset_wr_data", wr_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_burst('{11'h030, 6, 1'b1, 32'h99000000, 32'h00000101, 1'b0, 1'b0, 1, 1'b0}, n_we);
    chk("post_reset_we_count", n_we, 1);
    chk("post_reset_data", last_data,
        {32'h99000505, 32'h99000404, 32'h99000303, 32'h99000202, 32'h99000101, 32'h99000000});

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
